// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared fetch-stage types and constants.
// Optional FAULT state built with FETCH_ALIGN_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;
`endif

  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
    return addr & ~32'd3;
  endfunction

  function automatic logic misaligned(input logic [INST_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_adder.sv
// ============================================================================
// pc_adder : 32-bit +4 incrementer, wraps modulo 2^32.  Rev 1.0
// ============================================================================
`default_nettype none

module pc_adder
  import cpu_pkg::*;
(
  input  logic [INST_W-1:0] pc,
  output logic [INST_W-1:0] pc4
);

  assign pc4 = pc + 32'd4;

endmodule

`default_nettype wire

// File: rtl/pc_fetch.sv
// ============================================================================
// pc_fetch : PC register and single-outstanding instruction fetch handshake.
// Optional alignment fault with FETCH_ALIGN_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
  input  logic              CLK,
  input  logic              CLRN,
  input  logic [INST_W-1:0] NPC,
  output logic [INST_W-1:0] PC,
  output logic [INST_W-1:0] PC4,
  output logic              IM_REQ,
  output logic [INST_W-1:0] IM_ADDR,
  input  logic              IM_ACK,
  input  logic [INST_W-1:0] IM_RDATA,
  output logic [INST_W-1:0] INST,
  output logic              INST_VALID,
  input  logic              INST_READY
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              FAULT
`endif
);

  fetch_state_e      state_q;
  fetch_state_e      state_nxt;
  logic [INST_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;
  logic              accept;
  logic              mem_done;
  logic [INST_W-1:0] npc_load;

  assign mem_done = (state_q == ST_FETCH) && IM_ACK;
  assign accept   = (state_q == ST_HOLD) && INST_READY;

`ifdef FETCH_ALIGN_CHECK_EN
  assign npc_load = NPC;
`else
  assign npc_load = word_align(NPC);
`endif

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (IM_ACK) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (INST_READY) begin
`ifdef FETCH_ALIGN_CHECK_EN
          state_nxt = misaligned(NPC) ? ST_FAULT : ST_FETCH;
`else
          state_nxt = ST_FETCH;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      ST_FAULT: state_nxt = ST_FAULT;
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    IM_REQ     = (state_q == ST_FETCH);
    INST_VALID = (state_q == ST_HOLD);
`ifdef FETCH_ALIGN_CHECK_EN
    FAULT      = (state_q == ST_FAULT);
`endif
  end

  // PC and INST only move on the two handshake events, so both stay stable otherwise.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      pc_q   <= RESET_PC;
      inst_q <= '0;
    end else begin
      if (mem_done) inst_q <= IM_RDATA;
      if (accept)   pc_q   <= npc_load;
    end
  end

  assign PC      = pc_q;
  assign IM_ADDR = pc_q;
  assign INST    = inst_q;

  pc_adder u_pc_adder (
    .pc  (pc_q),
    .pc4 (PC4)
  );

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ============================================================================
// tb_pc_fetch : vector table, directed corner sequences and randomized run
// against a transaction-level model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        CLRN = 1'b0;
  logic [31:0] NPC = '0;
  logic [31:0] PC, PC4, IM_ADDR, INST;
  logic        IM_REQ, INST_VALID;
  logic        IM_ACK = 1'b0;
  logic [31:0] IM_RDATA = '0;
  logic        INST_READY = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        FAULT;
`endif

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .CLK        (CLK),
    .CLRN       (CLRN),
    .NPC        (NPC),
    .PC         (PC),
    .PC4        (PC4),
    .IM_REQ     (IM_REQ),
    .IM_ADDR    (IM_ADDR),
    .IM_ACK     (IM_ACK),
    .IM_RDATA   (IM_RDATA),
    .INST       (INST),
    .INST_VALID (INST_VALID),
    .INST_READY (INST_READY)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .FAULT      (FAULT)
`endif
  );

  always #5 CLK = ~CLK;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] npc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } vec_t;

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic ready,
                              input logic [31:0] npc, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] pc4);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.npc = npc;
    v.req = req; v.addr = addr; v.valid = valid; v.inst = inst; v.pc = pc; v.pc4 = pc4;
    return v;
  endfunction

  vec_t vecs[16];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Transaction-level reference: started / holding an instruction / faulted.
  bit          m_started, m_holding, m_faulted;
  logic [31:0] m_pc, m_inst;

  task automatic model_reset();
    m_started = 0; m_holding = 0; m_faulted = 0;
    m_pc = RST_PC; m_inst = '0;
  endtask

  task automatic model_step();
    if (m_faulted) begin
    end else if (!m_started) begin
      m_started = 1;
    end else if (!m_holding) begin
      if (IM_ACK) begin
        m_inst    = IM_RDATA;
        m_holding = 1;
      end
    end else if (INST_READY) begin
      m_holding = 0;
`ifdef FETCH_ALIGN_CHECK_EN
      m_pc = NPC;
      if (NPC % 4 != 0) m_faulted = 1;
`else
      m_pc = (NPC / 4) * 4;
`endif
    end
  endtask

  initial begin
    logic        exp_req;
    logic [31:0] exp_pc4;

    vecs[0]  = mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         32'h4);
    vecs[1]  = mk(1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         32'h4);
    vecs[2]  = mk(1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         32'h4);
    vecs[3]  = mk(1'b1, 32'h2008_0005, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h2008_0005, 32'h0,         32'h4);
    vecs[4]  = mk(1'b1, 32'hFFFF_0001, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h2008_0005, 32'h0,         32'h4);
    vecs[5]  = mk(1'b1, 32'hFFFF_0002, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h2008_0005, 32'h0,         32'h4);
    vecs[6]  = mk(1'b0, 32'hFFFF_0003, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h2008_0005, 32'h0,         32'h4);
    vecs[7]  = mk(1'b1, 32'hFFFF_0004, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h2008_0005, 32'h0,         32'h4);
    vecs[8]  = mk(1'b1, 32'hFFFF_0005, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h2008_0005, 32'h0,         32'h4);
    vecs[9]  = mk(1'b1, 32'hAAAA_AAAA, 1'b1, 32'h0000_0040, 1'b1, 32'h40,        1'b0, 32'h0,         32'h40,        32'h44);
    vecs[10] = mk(1'b0, 32'h0,         1'b1, 32'h0000_0080, 1'b1, 32'h40,        1'b0, 32'h0,         32'h40,        32'h44);
    vecs[11] = mk(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 32'h40,        1'b1, 32'hDEAD_BEEF, 32'h40,        32'h44);
    vecs[12] = mk(1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0);
    vecs[13] = mk(1'b1, 32'h0000_1234, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0000_1234, 32'hFFFF_FFFC, 32'h0);
    vecs[14] = mk(1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         32'h4);
    vecs[15] = mk(1'b1, 32'h1111_1111, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h1111_1111, 32'h0,         32'h4);

    // Reset values while CLRN is low.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_req",   {31'b0, IM_REQ},     32'h0);
    check("rst_addr",  IM_ADDR,             RST_PC);
    check("rst_pc",    PC,                  RST_PC);
    check("rst_pc4",   PC4,                 RST_PC + 32'd4);
    check("rst_valid", {31'b0, INST_VALID}, 32'h0);
    check("rst_inst",  INST,                32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_fault", {31'b0, FAULT},      32'h0);
`endif
    CLRN = 1'b1;
    #1;
    check("idle_req", {31'b0, IM_REQ}, 32'h0);
    tick();
    check("first_req",  {31'b0, IM_REQ}, 32'h1);
    check("first_addr", IM_ADDR,         32'h0);

    for (int i = 0; i < 16; i++) begin
      IM_ACK = vecs[i].ack; IM_RDATA = vecs[i].rdata;
      INST_READY = vecs[i].ready; NPC = vecs[i].npc;
      tick();
      check($sformatf("v%0d_req", i),   {31'b0, IM_REQ},     {31'b0, vecs[i].req});
      check($sformatf("v%0d_valid", i), {31'b0, INST_VALID}, {31'b0, vecs[i].valid});
      check($sformatf("v%0d_pc", i),    PC,                  vecs[i].pc);
      check($sformatf("v%0d_pc4", i),   PC4,                 vecs[i].pc4);
      if (vecs[i].req)   check($sformatf("v%0d_addr", i), IM_ADDR, vecs[i].addr);
      if (vecs[i].valid) check($sformatf("v%0d_inst", i), INST,    vecs[i].inst);
    end

    // Reset dropped mid-fetch, with a late acknowledge straddling release.
    IM_ACK = 1'b0; INST_READY = 1'b1; NPC = 32'h0000_0080;
    tick();
    INST_READY = 1'b0;
    check("mid_fetch_addr", IM_ADDR, 32'h80);
    #3;
    CLRN = 1'b0;
    IM_ACK = 1'b1; IM_RDATA = 32'h0BAD_0BAD;
    #1;
    check("arst_req",   {31'b0, IM_REQ},     32'h0);
    check("arst_pc",    PC,                  RST_PC);
    check("arst_valid", {31'b0, INST_VALID}, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    CLRN = 1'b1;
    tick();
    IM_ACK = 1'b0;
    check("late_ack_req",   {31'b0, IM_REQ},     32'h1);
    check("late_ack_valid", {31'b0, INST_VALID}, 32'h0);
    tick();
    check("late_ack_still_fetch", {31'b0, IM_REQ}, 32'h1);
    IM_ACK = 1'b1; IM_RDATA = 32'h5555_5555;
    tick();
    IM_ACK = 1'b0;
    check("post_rst_inst", INST, 32'h5555_5555);

    // Misaligned next PC.
    INST_READY = 1'b1; NPC = 32'h0000_0042;
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_fault", {31'b0, FAULT},      32'h1);
    check("mis_req",   {31'b0, IM_REQ},     32'h0);
    check("mis_valid", {31'b0, INST_VALID}, 32'h0);
    check("mis_pc",    PC,                  32'h42);
    IM_ACK = 1'b1; NPC = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fault_sticky", {31'b0, FAULT},  32'h1);
      check("fault_noreq",  {31'b0, IM_REQ}, 32'h0);
    end
`else
    check("mis_req",  {31'b0, IM_REQ}, 32'h1);
    check("mis_addr", IM_ADDR,         32'h40);
    check("mis_pc",   PC,              32'h40);
`endif

    // Randomized traffic against the reference model.
    IM_ACK = 1'b0; INST_READY = 1'b0;
    #2;
    CLRN = 1'b0;
    model_reset();
    @(negedge CLK);
    CLRN = 1'b1;
    for (int c = 0; c < 400; c++) begin
      IM_ACK     = ($urandom % 3) == 0;
      IM_RDATA   = $urandom;
      INST_READY = ($urandom % 2) == 0;
      NPC        = $urandom & 32'hFFFF_FFFC;
      if ($urandom % 16 == 0) NPC = 32'hFFFF_FFFC;
      if ($urandom % 48 == 0) NPC = NPC | 32'h1;
      model_step();
      tick();
      exp_req = m_started && !m_holding && !m_faulted;
      exp_pc4 = m_pc + 32'd4;
      check("rnd_req",   {31'b0, IM_REQ},     {31'b0, exp_req});
      check("rnd_valid", {31'b0, INST_VALID}, {31'b0, m_holding});
      check("rnd_pc",    PC,                  m_pc);
      check("rnd_pc4",   PC4,                 exp_pc4);
      if (exp_req)   check("rnd_addr", IM_ADDR, m_pc);
      if (m_holding) check("rnd_inst", INST,    m_inst);
`ifdef FETCH_ALIGN_CHECK_EN
      check("rnd_fault", {31'b0, FAULT}, {31'b0, m_faulted});
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
